// File: rtl/layer_motion_updater_pkg.sv
// layer_motion_updater_pkg: header register indices, flag bits and scan states shared by the motion updater.
package layer_motion_updater_pkg;
    localparam int LAYER_W = 5;
    localparam logic [2:0] REG_FLAGS = 3'd0;
    localparam logic [2:0] REG_W     = 3'd1;
    localparam logic [2:0] REG_H     = 3'd2;
    localparam logic [2:0] REG_X     = 3'd3;
    localparam logic [2:0] REG_Y     = 3'd4;
    localparam logic [2:0] REG_VX    = 3'd5;
    localparam logic [2:0] REG_VY    = 3'd6;
    localparam logic [2:0] REG_ANIM  = 3'd7;
    localparam int POPULATED = 0;
    localparam int SPRITE    = 1;
    localparam int HIDDEN    = 2;
    localparam int ANIMATED  = 3;
    typedef enum logic [3:0] {
        IDLE, RD_FLAGS, RD_X, RD_VX, WR_X, RD_Y, RD_VY, WR_Y, RD_ANIM, WR_ANIM, DONE
    } state_t;
endpackage

// File: rtl/layer_motion_updater_if.sv
// layer_motion_updater_if: controller read/write port of the layer header register file.
interface layer_motion_updater_if;
    logic [15:0] ctrlReadData;
    logic [4:0]  ctrlReadWriteLayer;
    logic [2:0]  layerRegisterIndex;
    logic [15:0] writeLayerData;
    logic        writeLayerEn;
    modport master (
        input  ctrlReadData,
        output ctrlReadWriteLayer, layerRegisterIndex, writeLayerData, writeLayerEn
    );
    modport slave (
        output ctrlReadData,
        input  ctrlReadWriteLayer, layerRegisterIndex, writeLayerData, writeLayerEn
    );
endinterface

// File: rtl/layer_motion_residue_ram.sv
// layer_motion_residue_ram: per-layer X/Y sub-pixel residues; async read, sync per-axis write, clear-all.
module layer_motion_residue_ram #(
    parameter int NUM_LAYERS = 32,
    parameter int FRAC_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 we_x_i,
    input  logic                 we_y_i,
    input  logic [4:0]           addr_i,
    input  logic [FRAC_BITS-1:0] wdata_i,
    output logic [FRAC_BITS-1:0] res_x_o,
    output logic [FRAC_BITS-1:0] res_y_o
);
    logic [NUM_LAYERS-1:0][2*FRAC_BITS-1:0] mem_q;

    assign res_x_o = mem_q[addr_i][FRAC_BITS-1:0];
    assign res_y_o = mem_q[addr_i][2*FRAC_BITS-1:FRAC_BITS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mem_q <= '0;
        else if (clr_i) mem_q <= '0;
        else begin
            if (we_x_i) mem_q[addr_i][FRAC_BITS-1:0] <= wdata_i;
            if (we_y_i) mem_q[addr_i][2*FRAC_BITS-1:FRAC_BITS] <= wdata_i;
        end
    end
endmodule

// File: rtl/layer_motion_updater.sv
// layer_motion_updater: on frameStart walks all layers, applying sprite velocity (with sub-pixel residue)
// and animation frame advance through the controller header port.
module layer_motion_updater
    import layer_motion_updater_pkg::*;
#(
    parameter int NUM_LAYERS = 32,
    parameter int FRAC_BITS  = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic frameStart,
    input  logic clrFrac,
    layer_motion_updater_if.master bus,
    output logic busy,
    output logic done,
    output logic overrun
);
    state_t state_q, state_d;
    logic [LAYER_W-1:0] layer_q, layer_d;
    logic anim_q, anim_d;
    logic [15:0] pos_q, pos_d, data_q, data_d;
    logic [FRAC_BITS-1:0] res_x, res_y;
    logic [16+FRAC_BITS-1:0] acc;
    logic [8:0] next_frame;
    logic [7:0] new_frame;
    logic [15:0] rd;
    logic last, adv;

    assign rd = bus.ctrlReadData;
    // Position and residue form one fixed-point word so carries out of the fraction land in the pixel part.
    assign acc = {pos_q, state_q == RD_VX ? res_x : res_y} + {{FRAC_BITS{rd[15]}}, rd};
    assign next_frame = {1'b0, rd[15:8]} + 9'd1;
    assign new_frame = (rd[7:0] == 8'd0 || next_frame >= {1'b0, rd[7:0]}) ? 8'd0 : next_frame[7:0];
    assign last = layer_q == LAYER_W'(NUM_LAYERS - 1);

    layer_motion_residue_ram #(.NUM_LAYERS(NUM_LAYERS), .FRAC_BITS(FRAC_BITS)) u_res (
        .clk    (clk),
        .rst    (reset),
        .clr_i  (clrFrac && state_q == IDLE),
        .we_x_i (state_q == RD_VX),
        .we_y_i (state_q == RD_VY),
        .addr_i (layer_q),
        .wdata_i(acc[FRAC_BITS-1:0]),
        .res_x_o(res_x),
        .res_y_o(res_y)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            layer_q <= '0;
            anim_q  <= 1'b0;
            pos_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            anim_q  <= anim_d;
            pos_q   <= pos_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        anim_d  = anim_q;
        pos_d   = pos_q;
        data_d  = data_q;
        adv     = 1'b0;
        case (state_q)
            IDLE: if (frameStart) begin
                state_d = RD_FLAGS;
                layer_d = '0;
            end
            RD_FLAGS: begin
                anim_d = rd[ANIMATED];
                if (rd[POPULATED] && rd[SPRITE]) state_d = RD_X;
                else adv = 1'b1;
            end
            RD_X: begin
                pos_d   = rd;
                state_d = RD_VX;
            end
            RD_VX: begin
                data_d  = acc[16+FRAC_BITS-1:FRAC_BITS];
                state_d = WR_X;
            end
            WR_X: state_d = RD_Y;
            RD_Y: begin
                pos_d   = rd;
                state_d = RD_VY;
            end
            RD_VY: begin
                data_d  = acc[16+FRAC_BITS-1:FRAC_BITS];
                state_d = WR_Y;
            end
            WR_Y: if (anim_q) state_d = RD_ANIM; else adv = 1'b1;
            RD_ANIM: begin
                data_d  = {new_frame, rd[7:0]};
                state_d = WR_ANIM;
            end
            WR_ANIM: adv = 1'b1;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (adv) begin
            state_d = last ? DONE : RD_FLAGS;
            layer_d = last ? layer_q : layer_q + 5'd1;
        end
    end

    assign bus.ctrlReadWriteLayer = layer_q;
    assign bus.writeLayerData     = data_q;
    assign bus.writeLayerEn       = state_q inside {WR_X, WR_Y, WR_ANIM};
    assign bus.layerRegisterIndex = (state_q inside {RD_X, WR_X}) ? REG_X :
                                    (state_q inside {RD_Y, WR_Y}) ? REG_Y :
                                    (state_q == RD_VX) ? REG_VX :
                                    (state_q == RD_VY) ? REG_VY :
                                    (state_q inside {RD_ANIM, WR_ANIM}) ? REG_ANIM : REG_FLAGS;
    assign busy    = state_q != IDLE;
    assign done    = state_q == DONE;
    assign overrun = frameStart && state_q != IDLE;
endmodule

// File: tb/tb_layer_motion_updater.sv
// tb_layer_motion_updater: directed scenarios against a behavioural header register file.
module tb_layer_motion_updater;
    logic clk, reset, frameStart, clrFrac, busy, done, overrun;
    logic [15:0] regs [32][8];
    logic [23:0] wlog [$];
    int checks = 0;
    int failures = 0;

    layer_motion_updater_if bus ();

    layer_motion_updater dut (
        .clk       (clk),
        .reset     (reset),
        .frameStart(frameStart),
        .clrFrac   (clrFrac),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    assign bus.ctrlReadData = regs[bus.ctrlReadWriteLayer][bus.layerRegisterIndex];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.writeLayerEn) begin
            regs[bus.ctrlReadWriteLayer][bus.layerRegisterIndex] = bus.writeLayerData;
            wlog.push_back({bus.ctrlReadWriteLayer, bus.layerRegisterIndex, bus.writeLayerData});
        end
    endtask

    task automatic clear_mem();
        for (int l = 0; l < 32; l++)
            for (int r = 0; r < 8; r++) regs[l][r] = 16'h0000;
    endtask

    task automatic run_frame(input logic clr, output int cyc, output int dn);
        wlog.delete();
        clrFrac = clr;
        frameStart = 1'b1;
        step();
        frameStart = 1'b0;
        clrFrac = 1'b0;
        cyc = 0;
        dn = 0;
        while (busy && cyc < 200) begin
            cyc++;
            if (done) dn++;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, overrun, bus.writeLayerEn} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {busy, done, overrun, bus.writeLayerEn});
        end
        checks++;
        if ({bus.ctrlReadWriteLayer, bus.layerRegisterIndex} !== 8'h00) begin
            failures++;
            $display("FAIL reset_addr got=%h exp=00", {bus.ctrlReadWriteLayer, bus.layerRegisterIndex});
        end
        checks++;
        if (bus.writeLayerData !== 16'h0000) begin
            failures++;
            $display("FAIL reset_wdata got=%h exp=0000", bus.writeLayerData);
        end
        step();
        step();
        reset = 1'b0;
        step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_move();
        int cyc, dn;
        clear_mem();
        regs[0][0] = 16'h0003;
        regs[0][3] = 16'd100;
        regs[0][5] = 16'd64;
        run_frame(1'b1, cyc, dn);
        checks++;
        if (cyc !== 39) begin failures++; $display("FAIL move_cycles got=%0d exp=39", cyc); end
        checks++;
        if (dn !== 1) begin failures++; $display("FAIL move_done got=%0d exp=1", dn); end
        checks++;
        if (regs[0][3] !== 16'd101) begin failures++; $display("FAIL move_x got=%0d exp=101", regs[0][3]); end
        checks++;
        if (regs[0][4] !== 16'd0) begin failures++; $display("FAIL move_y got=%0d exp=0", regs[0][4]); end
        checks++;
        if (wlog.size() !== 2) begin failures++; $display("FAIL move_writes got=%0d exp=2", wlog.size()); end
    endtask

    task automatic test_residue();
        int cyc, dn;
        logic [15:0] exp_x [4] = '{16'd100, 16'd101, 16'd101, 16'd101};
        logic clr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        clear_mem();
        regs[0][0] = 16'h0003;
        regs[0][3] = 16'd100;
        regs[0][5] = 16'd32;
        for (int f = 0; f < 4; f++) begin
            run_frame(clr[f], cyc, dn);
            checks++;
            if (regs[0][3] !== exp_x[f]) begin
                failures++;
                $display("FAIL residue_frame%0d got=%0d exp=%0d", f, regs[0][3], exp_x[f]);
            end
        end
    endtask

    task automatic test_wrap();
        int cyc, dn;
        clear_mem();
        regs[0][0] = 16'h0003;
        regs[0][3] = 16'h0000;
        regs[0][5] = 16'hFFC0;
        run_frame(1'b1, cyc, dn);
        checks++;
        if (regs[0][3] !== 16'hFFFF) begin failures++; $display("FAIL wrap_neg got=%h exp=ffff", regs[0][3]); end
        regs[0][3] = 16'h7FFF;
        regs[0][5] = 16'd64;
        run_frame(1'b1, cyc, dn);
        checks++;
        if (regs[0][3] !== 16'h8000) begin failures++; $display("FAIL wrap_pos got=%h exp=8000", regs[0][3]); end
    endtask

    task automatic test_anim();
        int cyc, dn;
        clear_mem();
        regs[5][0] = 16'h000B;
        regs[5][7] = 16'h0304;
        regs[6][0] = 16'h000B;
        regs[6][7] = 16'h0500;
        run_frame(1'b1, cyc, dn);
        checks++;
        if (regs[5][7] !== 16'h0004) begin failures++; $display("FAIL anim_wrap got=%h exp=0004", regs[5][7]); end
        checks++;
        if (regs[6][7] !== 16'h0000) begin failures++; $display("FAIL anim_zero got=%h exp=0000", regs[6][7]); end
        checks++;
        if (cyc !== 49) begin failures++; $display("FAIL anim_cycles got=%0d exp=49", cyc); end
    endtask

    task automatic test_skip();
        int cyc, dn;
        clear_mem();
        regs[0][0] = 16'h0001;
        regs[2][0] = 16'h0003;
        regs[2][3] = 16'd10;
        run_frame(1'b1, cyc, dn);
        checks++;
        if (cyc !== 39) begin failures++; $display("FAIL skip_cycles got=%0d exp=39", cyc); end
        checks++;
        if (wlog.size() !== 2) begin
            failures++;
            $display("FAIL skip_writes got=%0d exp=2", wlog.size());
        end else begin
            checks++;
            if (wlog[0] !== {5'd2, 3'd3, 16'd10} || wlog[1] !== {5'd2, 3'd4, 16'd0}) begin
                failures++;
                $display("FAIL skip_log got=%h,%h exp=%h,%h", wlog[0], wlog[1], {5'd2, 3'd3, 16'd10}, {5'd2, 3'd4, 16'd0});
            end
        end
    endtask

    task automatic test_overrun();
        int cyc = 0;
        clear_mem();
        regs[2][0] = 16'h0003;
        frameStart = 1'b1;
        step();
        frameStart = 1'b0;
        while (busy && cyc < 200) begin
            cyc++;
            if (cyc == 3) begin
                frameStart = 1'b1;
                #1;
                checks++;
                if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_pulse got=%b exp=1", overrun); end
            end
            step();
            frameStart = 1'b0;
            if (cyc == 3) begin
                #1;
                checks++;
                if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
            end
        end
        checks++;
        if (cyc !== 39) begin failures++; $display("FAIL overrun_cycles got=%0d exp=39", cyc); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int cyc, dn;
        clear_mem();
        regs[0][0] = 16'h0003;
        regs[0][3] = 16'd100;
        regs[0][5] = 16'd32;
        clrFrac = 1'b1;
        frameStart = 1'b1;
        step();
        frameStart = 1'b0;
        clrFrac = 1'b0;
        while (!(bus.writeLayerEn && bus.layerRegisterIndex == 3'd4) && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL rstmid_wait got=%0d exp=<20", n); end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.writeLayerEn !== 1'b0) begin failures++; $display("FAIL rstmid_wen got=%b exp=0", bus.writeLayerEn); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        step();
        reset = 1'b0;
        step();
        run_frame(1'b0, cyc, dn);
        checks++;
        if (regs[0][3] !== 16'd100) begin failures++; $display("FAIL rstmid_residue got=%0d exp=100", regs[0][3]); end
    endtask

    initial begin
        frameStart = 1'b0;
        clrFrac = 1'b0;
        clear_mem();
        test_reset();
        test_move();
        test_residue();
        test_wrap();
        test_anim();
        test_skip();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
